// File: rtl/fir_pkg.sv
// Shared FIR definitions: default sample width, sample type and the signed
// saturation limits used by every tap.
package fir_pkg;

   localparam int FIR_N     = 32;
   localparam int FIR_LIM_W = 128;

   typedef logic signed [FIR_N-1:0] fir_sample_t;

   // Largest value representable in an n-bit two's complement word (n <= 127).
   function automatic logic signed [FIR_LIM_W-1:0] FIR_MAX(input int n);
      logic signed [FIR_LIM_W-1:0] one_v;
      one_v   = 128'sd1;
      FIR_MAX = (one_v <<< (n - 1)) - one_v;
   endfunction

   // Smallest value representable in an n-bit two's complement word.
   function automatic logic signed [FIR_LIM_W-1:0] FIR_MIN(input int n);
      FIR_MIN = ~FIR_MAX(n);
   endfunction

endpackage

// File: rtl/tapped_delay_block_chk.sv
// Property checker for the tap's delay register, instantiated by the top.
module tapped_delay_block_chk
   import fir_pkg::*;
#(
   parameter int N = FIR_N
) (
   input logic                clk,
   input logic                rst,
   input logic                ena,
   input logic signed [N-1:0] x_in,
   input logic signed [N-1:0] x_out
);

   a_rst_clears : assert property (@(posedge clk) rst |=> (x_out == {N{1'b0}}));
   a_ena_loads  : assert property (@(posedge clk) (!rst && ena) |=> (x_out == $past(x_in)));
   a_hold       : assert property (@(posedge clk) (!rst && !ena) |=> $stable(x_out));

endmodule

// File: rtl/tdb_mac.sv
// Combinational multiply-add of one FIR tap: y_out = y_in + b*x_in.
// Wraps modulo 2^N unless TAPPED_DELAY_SAT_EN selects saturating arithmetic.
module tdb_mac
   import fir_pkg::*;
#(
   parameter int N = FIR_N
) (
   input  logic signed [N-1:0] x_in,
   input  logic signed [N-1:0] b,
   input  logic signed [N-1:0] y_in,
   output logic signed [N-1:0] y_out
);

`ifdef TAPPED_DELAY_SAT_EN
   localparam logic signed [2*N-1:0] P_MAX = (2*N)'(FIR_MAX(N));
   localparam logic signed [2*N-1:0] P_MIN = (2*N)'(FIR_MIN(N));
   localparam logic signed [N:0]     S_MAX = (N+1)'(FIR_MAX(N));
   localparam logic signed [N:0]     S_MIN = (N+1)'(FIR_MIN(N));

   logic signed [2*N-1:0] prod_s;
   logic signed [N-1:0]   p_clamp_s;
   logic signed [N:0]     sum_s;

   // Operands are sign-extended to 2N bits by context, giving the full product.
   assign prod_s = b * x_in;

   // Clamp the full product, then clamp the one-bit-wider sum.
   always_comb begin
      p_clamp_s = prod_s[N-1:0];
      sum_s     = {(N+1){1'b0}};
      y_out     = {N{1'b0}};
      if (prod_s > P_MAX) begin
         p_clamp_s = P_MAX[N-1:0];
      end else if (prod_s < P_MIN) begin
         p_clamp_s = P_MIN[N-1:0];
      end else begin
         p_clamp_s = prod_s[N-1:0];
      end
      sum_s = (N+1)'(y_in) + (N+1)'(p_clamp_s);
      if (sum_s > S_MAX) begin
         y_out = S_MAX[N-1:0];
      end else if (sum_s < S_MIN) begin
         y_out = S_MIN[N-1:0];
      end else begin
         y_out = sum_s[N-1:0];
      end
   end
`else
   logic signed [N-1:0] prod_s;

   // The low N bits of the product are all a wrapping sum needs.
   assign prod_s = b * x_in;
   assign y_out  = y_in + prod_s;
`endif

endmodule

// File: rtl/tapped_delay_block.sv
// One direct-form FIR tap: enabled one-sample delay plus combinational MAC.
// Optional macro TAPPED_DELAY_SAT_EN makes the MAC saturate instead of wrap.
module tapped_delay_block
   import fir_pkg::*;
#(
   parameter int N = FIR_N
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic signed [N-1:0] x_in,
   input  logic signed [N-1:0] b,
   input  logic signed [N-1:0] y_in,
   output logic signed [N-1:0] x_out,
   output logic signed [N-1:0] y_out
);

   logic signed [N-1:0] x_dly_r;

   // Sample delay register; reset wins over the advance enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_dly_r <= {N{1'b0}};
      end else if (ena) begin
         x_dly_r <= x_in;
      end else begin
         x_dly_r <= x_dly_r;
      end
   end

   assign x_out = x_dly_r;

   // The tap's own contribution uses the undelayed sample.
   tdb_mac #(.N(N)) u_mac (
      .x_in  (x_in),
      .b     (b),
      .y_in  (y_in),
      .y_out (y_out)
   );

   tapped_delay_block_chk #(.N(N)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .x_in  (x_in),
      .x_out (x_dly_r)
   );

endmodule

// File: tb/tb_tapped_delay_block.sv
// Directed bench for tapped_delay_block: single tap, 4-tap chain and an 8-bit tap
// for overflow behaviour; expectations queued at stimulus time.
module tb_tapped_delay_block;
   import fir_pkg::*;

   logic clk = 1'b0;
   logic rst, ena;

   fir_sample_t x_in, b, y_in, x_out, y_out;

   logic signed [31:0] cx;
   logic signed [31:0] c_x [0:4];
   logic signed [31:0] c_y [0:4];

   logic signed [7:0] x8, b8, y8, x8_out, y8_out;

   longint sb_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tapped_delay_block #(.N(32)) dut (
      .clk(clk), .rst(rst), .ena(ena), .x_in(x_in), .b(b), .y_in(y_in),
      .x_out(x_out), .y_out(y_out)
   );

   assign c_x[0] = cx;
   assign c_y[0] = 32'sd0;
   for (genvar k = 0; k < 4; k++) begin : g_tap
      tapped_delay_block #(.N(32)) u_tap (
         .clk(clk), .rst(rst), .ena(ena), .x_in(c_x[k]), .b(32'(k + 1)),
         .y_in(c_y[k]), .x_out(c_x[k+1]), .y_out(c_y[k+1])
      );
   end

   tapped_delay_block #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .ena(ena), .x_in(x8), .b(b8), .y_in(y8),
      .x_out(x8_out), .y_out(y8_out)
   );

   // Reference MAC: exact product and sum, then wrap or saturate to n bits.
   function automatic longint mac_model(input int n, input longint bb, input longint xx,
                                        input longint yy);
      longint mx, mn, p, s;
      mx = (64'sd1 <<< (n - 1)) - 64'sd1;
      mn = -mx - 64'sd1;
      p  = bb * xx;
`ifdef TAPPED_DELAY_SAT_EN
      if (p > mx) p = mx;
      else if (p < mn) p = mn;
      s = yy + p;
      if (s > mx) s = mx;
      else if (s < mn) s = mn;
      return s;
`else
      s = yy + p;
      return (s <<< (64 - n)) >>> (64 - n);
`endif
   endfunction

   task automatic push(input longint e);
      sb_q.push_back(e);
   endtask

   task automatic check(input string tag, input longint obs);
      longint exp_v;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty, observed %0d", tag, obs);
      end else begin
         exp_v = sb_q.pop_front();
         checks++;
         assert (obs === exp_v)
         else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rb, rx, ry;

      // Reset with ena high and a live sample; MAC still active during reset.
      rst = 1'b1; ena = 1'b1; x_in = 32'sd7; b = 32'sd3; y_in = 32'sd100;
      cx = 32'sd0; x8 = 8'sd0; b8 = 8'sd0; y8 = 8'sd0;
      push(0);
      tick();
      check("reset_x_out", longint'(x_out));
      push(121);
      check("reset_y_out", longint'(y_out));

      rst = 1'b0;
      push(7);
      tick();
      check("first_load", longint'(x_out));

      // Combinational MAC, no clock edge.
      x_in = -32'sd5; b = 32'sd3; y_in = 32'sd100;
      push(85);
      #1;
      check("mac_basic", longint'(y_out));

      // Enable hold.
      x_in = 32'sd9;
      push(9);
      tick();
      check("load_9", longint'(x_out));
      ena = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         x_in = 32'(i);
         push(9);
         tick();
         check("hold", longint'(x_out));
      end
      y_in = 32'sd0;
      push(9);
      #1;
      check("ena_low_y_out", longint'(y_out));
      ena = 1'b1;
      push(3);
      tick();
      check("reload", longint'(x_out));

      // Mid-stream reset pulse.
      for (int i = 10; i <= 14; i++) begin
         x_in = 32'(i);
         rst  = (i == 12);
         push((i == 12) ? 0 : i);
         tick();
         check("stream_rst", longint'(x_out));
      end
      rst = 1'b0;

      // Random MAC patterns.
      for (int i = 0; i < 6; i++) begin
         rb = int'($urandom());
         rx = int'($urandom());
         ry = int'($urandom());
         if (i < 2) begin
            rb = rb % 1000;
            rx = rx % 1000;
         end
         b = rb; x_in = rx; y_in = ry;
         push(mac_model(32, longint'(rb), longint'(rx), longint'(ry)));
         #1;
         check("mac_rand", longint'(y_out));
      end

      // Four-tap chain impulse response.
      cx = 32'sd0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cx = (i == 0) ? 32'sd1 : 32'sd0;
         push((i < 4) ? (i + 1) : 0);
         #1;
         check("chain_impulse", longint'(c_y[4]));
         tick();
      end

      // Eight-bit overflow cases.
      b8 = 8'sd64; x8 = 8'sd4; y8 = 8'sd0;
`ifdef TAPPED_DELAY_SAT_EN
      push(127);
`else
      push(0);
`endif
      #1;
      check("ovf_pos", longint'(y8_out));
      b8 = -8'sd64; x8 = 8'sd2; y8 = -8'sd100;
`ifdef TAPPED_DELAY_SAT_EN
      push(-128);
`else
      push(28);
`endif
      #1;
      check("ovf_neg", longint'(y8_out));
      b8 = -8'sd128; x8 = -8'sd128; y8 = 8'sd127;
      push(mac_model(8, -128, -128, 127));
      #1;
      check("ovf_min_min", longint'(y8_out));

      if (sb_q.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
